sel_step_control: RTL and testbench
===================================

Name: sel_step_control

Overview:
- Parametrised multi-channel selector controller. It replaces the fixed two-register border/bar stepper.
- Each of N_CH channels holds a W-bit value in 0..MAX_VAL, stepped up or down by edge-detected button presses.
- End-of-range behaviour is either wrap or saturate.
- Sits between the debounced board buttons and the game/render logic. Outputs drive selection inputs (border style, bar position, etc.) directly.

Parameters:
- N_CH, 2, number of independent selector channels
- W, 2, bits per channel value
- MAX_VAL, 2, highest legal value per channel; must be < 2**W
- DEFAULT_VAL, 1, value loaded on reset and while sw_on low; must be <= MAX_VAL
- WRAP, 1, 1 = wrap at range ends (MAX_VAL->0 up, 0->MAX_VAL down); 0 = saturate
- REPEAT_DELAY, 25000000, cycles a button must be held before the first auto-repeat step (AUTOREPEAT_EN only)
- REPEAT_RATE, 10000000, cycles between subsequent auto-repeat steps (AUTOREPEAT_EN only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw_on  in  1  enable; low forces all channels to DEFAULT_VAL
- btn_up  in  N_CH  per-channel increment button, level, already debounced
- btn_dn  in  N_CH  per-channel decrement button, level, already debounced
- sel  out  N_CH*W  channel values, channel k at bits [k*W +: W], registered
- changed  out  N_CH  one-cycle pulse, registered, same cycle the new sel value appears

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state updates on posedge clk.
- Reset (rst=1):
  - sel = DEFAULT_VAL on every channel; changed = 0.
  - Button-history registers btn_up_q and btn_dn_q = all ones, so buttons held through reset do not step.
  - Repeat FSMs go to IDLE.
- Edge detect per channel: up_ev = btn_up & ~btn_up_q; dn_ev = btn_dn & ~btn_dn_q. The history registers update every non-reset cycle, including while sw_on=0.
- Latency: a button sampled high at edge t (low at t-1) updates sel and pulses changed at edge t, i.e. visible 1 cycle after first sampled.
- Step rules per channel, evaluated independently:
  - up_ev only: if v==MAX_VAL then (WRAP ? 0 : MAX_VAL), else v+1.
  - dn_ev only: if v==0 then (WRAP ? MAX_VAL : 0), else v-1.
  - up_ev and dn_ev in the same cycle: no change.
  - Any out-of-range value (v > MAX_VAL) is forced to MAX_VAL on the next step attempt, in either direction.
- changed=1 only when the value actually differs. Saturating at a limit gives changed=0.
- sw_on=0:
  - sel = DEFAULT_VAL, changed = 0, FSMs IDLE; the history registers keep tracking.
  - A button held across the sw_on rise does not step.
  - Entering DEFAULT_VAL because sw_on dropped does not pulse changed.
- rst has priority over sw_on; sw_on has priority over button events.
- Channels never interact. Simultaneous events on different channels are all applied in the same cycle.

Optional Feature:
- Macro AUTOREPEAT_EN.
- Defined: per-channel FSM with states IDLE, DELAY, REPEAT and a counter of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - IDLE -> DELAY on a single-direction edge event (the step itself is applied as normal); the counter clears.
  - DELAY -> REPEAT when the counter reaches REPEAT_DELAY-1 with the same button still held alone. This applies one step and clears the counter.
  - REPEAT applies one step every REPEAT_RATE cycles while the button stays held alone.
  - Any state -> IDLE on: button release, the other button asserted, sw_on=0, or rst.
  - Repeat steps obey the same wrap/saturate and changed rules.
- Not defined: no FSM or counters are synthesised; only edge events step; a held button produces exactly one step.

Test Plan (defaults N_CH=2, W=2, MAX_VAL=2, DEFAULT_VAL=1, WRAP=1; REPEAT_DELAY=8, REPEAT_RATE=4 where used):
- rst held 2 cycles with btn_up[0] high, then released; btn_up[0] held -> sel={1,1}, changed=0, no step.
- sw_on=1, btn_up[0] pulsed three times (one cycle each, gaps >=1) -> ch0 goes 2, 0, 1; changed[0] pulses 3 times; ch1 stays 1.
- WRAP=0, ch1 from 1: btn_dn[1] pulsed twice -> 0, then 0 with changed[1]=0 on the second press; then btn_up[1] x3 -> 1, 2, 2.
- btn_up[0] and btn_dn[0] rise on the same cycle -> no change, changed=0. In the same cycle btn_up[1] rises -> ch1 steps 1->2 normally.
- sw_on dropped mid-hold with ch0=2 -> sel={1,1} next cycle, no changed pulse. sw_on raised while btn_up[0] still high -> no step until release and re-press.
- AUTOREPEAT_EN: btn_up[0] held 20 cycles from ch0=0:
  - First step on the first cycle (0->1).
  - Repeat step 8 cycles later (1->2).
  - Then one every 4 cycles (2->0, 0->1).
  - Releasing or asserting btn_dn[0] stops repeats immediately.

Source files
------------

// File: rtl/sel_step_control.sv
// Multi-channel up/down selector stepped by debounced button edges, wrap or saturate; hold auto-repeat under AUTOREPEAT_EN.
// Latency: one cycle from first sampled press to sel/changed; no backpressure, every accepted event is applied.
module sel_step_control #(
    parameter int N_CH         = 2,
    parameter int W            = 2,
    parameter int MAX_VAL      = 2,
    parameter int DEFAULT_VAL  = 1,
    parameter int WRAP         = 1,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_on,
    input  logic [N_CH-1:0]   btn_up,
    input  logic [N_CH-1:0]   btn_dn,
    output logic [N_CH*W-1:0] sel,
    output logic [N_CH-1:0]   changed
);

    localparam logic [W-1:0] MAXV = W'(MAX_VAL);
    localparam logic [W-1:0] DEFV = W'(DEFAULT_VAL);

    generate
        if (MAX_VAL < 0 || MAX_VAL >= (1 << W) || DEFAULT_VAL < 0 || DEFAULT_VAL > MAX_VAL ||
            REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
            $error("sel_step_control: illegal parameter set");
        end
    endgenerate

    logic [N_CH-1:0]   btn_up_q;
    logic [N_CH-1:0]   btn_dn_q;
    logic [N_CH-1:0]   up_ev;
    logic [N_CH-1:0]   dn_ev;
    logic [N_CH-1:0]   rep_up;
    logic [N_CH-1:0]   rep_dn;
    logic [N_CH*W-1:0] sel_nxt;
    logic [N_CH-1:0]   chg_nxt;

    assign up_ev = btn_up & ~btn_up_q;
    assign dn_ev = btn_dn & ~btn_dn_q;

    // Opposing requests cancel; an out-of-range value snaps to MAX_VAL on any attempt.
    function automatic logic [W-1:0] next_val(input logic [W-1:0] v, input logic up, input logic dn);
        logic [W-1:0] r;
        r = v;
        if (up && !dn) begin
            if (v > MAXV)       r = MAXV;
            else if (v == MAXV) r = (WRAP != 0) ? '0 : MAXV;
            else                r = v + 1'b1;
        end else if (dn && !up) begin
            if (v > MAXV)       r = MAXV;
            else if (v == '0)   r = (WRAP != 0) ? MAXV : '0;
            else                r = v - 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        sel_nxt = sel;
        chg_nxt = '0;
        for (int k = 0; k < N_CH; k++) begin
            sel_nxt[k*W +: W] = next_val(sel[k*W +: W], up_ev[k] | rep_up[k], dn_ev[k] | rep_dn[k]);
            chg_nxt[k]        = (sel_nxt[k*W +: W] != sel[k*W +: W]);
        end
    end

    // History keeps tracking while disabled so a button held across sw_on rising never steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= {N_CH{DEFV}};
            changed  <= '0;
            btn_up_q <= '1;
            btn_dn_q <= '1;
        end else begin
            btn_up_q <= btn_up;
            btn_dn_q <= btn_dn;
            if (!sw_on) begin
                sel     <= {N_CH{DEFV}};
                changed <= '0;
            end else begin
                sel     <= sel_nxt;
                changed <= chg_nxt;
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    rpt_state_t      st_q  [N_CH];
    rpt_state_t      st_d  [N_CH];
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0] dir_q;
    logic [N_CH-1:0] dir_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                st_q[k]  <= IDLE;
                cnt_q[k] <= '0;
            end
            dir_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // dir_q=1 tracks the up button; the run continues only while that button is held alone.
    always_comb begin
        logic held;
        held   = 1'b0;
        st_d   = st_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        rep_up = '0;
        rep_dn = '0;
        for (int k = 0; k < N_CH; k++) begin
            held = dir_q[k] ? (btn_up[k] & ~btn_dn[k]) : (btn_dn[k] & ~btn_up[k]);
            case (st_q[k])
                IDLE: begin
                    if (sw_on && (up_ev[k] ^ dn_ev[k])) begin
                        st_d[k]  = DELAY;
                        cnt_d[k] = '0;
                        dir_d[k] = up_ev[k];
                    end
                end
                DELAY: begin
                    if (!sw_on || !held) begin
                        st_d[k] = IDLE;
                    end else if (cnt_q[k] == DLY_LAST) begin
                        st_d[k]   = REPEAT;
                        cnt_d[k]  = '0;
                        rep_up[k] = dir_q[k];
                        rep_dn[k] = ~dir_q[k];
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!sw_on || !held) begin
                        st_d[k] = IDLE;
                    end else if (cnt_q[k] == RATE_LAST) begin
                        cnt_d[k]  = '0;
                        rep_up[k] = dir_q[k];
                        rep_dn[k] = ~dir_q[k];
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                default: st_d[k] = IDLE;
            endcase
        end
    end
`else
    assign rep_up = '0;
    assign rep_dn = '0;
`endif

endmodule

// File: tb/tb_sel_step_control.sv
// Bench for sel_step_control: a wrapping and a saturating instance share stimulus and are checked against a per-cycle behavioural model.
module tb_sel_step_control;
    localparam int N   = 2;
    localparam int MXV = 2;
    localparam int DEF = 1;
    localparam int RD  = 8;
    localparam int RR  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sw_on;
    logic [N-1:0] btn_up;
    logic [N-1:0] btn_dn;
    logic [3:0]   sel_w, sel_s;
    logic [1:0]   chg_w, chg_s;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sel_step_control #(.N_CH(N), .W(2), .MAX_VAL(MXV), .DEFAULT_VAL(DEF), .WRAP(1),
                       .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_w (
        .clk(clk), .rst(rst), .sw_on(sw_on), .btn_up(btn_up), .btn_dn(btn_dn),
        .sel(sel_w), .changed(chg_w));

    sel_step_control #(.N_CH(N), .W(2), .MAX_VAL(MXV), .DEFAULT_VAL(DEF), .WRAP(0),
                       .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_s (
        .clk(clk), .rst(rst), .sw_on(sw_on), .btn_up(btn_up), .btn_dn(btn_dn),
        .sel(sel_s), .changed(chg_s));

    // ---------------- behavioural model (index 0 = wrap, 1 = saturate)
    int mval [2][N];
    bit mchg [2][N];
    bit pu [N];
    bit pd [N];
`ifdef AUTOREPEAT_EN
    bit act  [N];
    bit adir [N];
    int age  [N];
`endif

    function automatic int step(input int v, input bit up, input bit dn, input bit wrap);
        if (up == dn) return v;
        if (v > MXV) return MXV;
        if (up) return wrap ? (v + 1) % (MXV + 1) : ((v + 1 > MXV) ? MXV : v + 1);
        return wrap ? (v + MXV) % (MXV + 1) : ((v == 0) ? 0 : v - 1);
    endfunction

    always @(posedge clk) begin : model
        bit uev, dev, up, dn;
        int nv;
`ifdef AUTOREPEAT_EN
        bit was, rep;
`endif
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    mval[d][k] = DEF;
                    mchg[d][k] = 1'b0;
                end
                pu[k] = 1'b1;
                pd[k] = 1'b1;
`ifdef AUTOREPEAT_EN
                act[k] = 1'b0;
`endif
            end else begin
                uev = btn_up[k] && !pu[k];
                dev = btn_dn[k] && !pd[k];
                up  = uev;
                dn  = dev;
`ifdef AUTOREPEAT_EN
                was = act[k];
                rep = 1'b0;
                if (act[k]) begin
                    if (sw_on && (adir[k] ? (btn_up[k] && !btn_dn[k]) : (btn_dn[k] && !btn_up[k]))) begin
                        age[k]++;
                        rep = (age[k] == RD) || (age[k] > RD && (age[k] - RD) % RR == 0);
                    end else begin
                        act[k] = 1'b0;
                    end
                end
                if (!was && sw_on && (uev != dev)) begin
                    act[k]  = 1'b1;
                    adir[k] = uev;
                    age[k]  = 0;
                end
                up = up || (rep && adir[k]);
                dn = dn || (rep && !adir[k]);
`endif
                for (int d = 0; d < 2; d++) begin
                    if (!sw_on) begin
                        mval[d][k] = DEF;
                        mchg[d][k] = 1'b0;
                    end else begin
                        nv = step(mval[d][k], up, dn, d == 0);
                        mchg[d][k] = (nv != mval[d][k]);
                        mval[d][k] = nv;
                    end
                end
                pu[k] = btn_up[k];
                pd[k] = btn_dn[k];
            end
        end
    end

    function automatic logic [3:0] exp_sel(input int d);
        return {2'(mval[d][1]), 2'(mval[d][0])};
    endfunction

    function automatic logic [1:0] exp_chg(input int d);
        return {mchg[d][1], mchg[d][0]};
    endfunction

    task automatic chk(input string name, input logic [7:0] act_v, input logic [7:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_sel_wrap", sel_w, exp_sel(0));
            chk("model_chg_wrap", chg_w, exp_chg(0));
            chk("model_sel_sat",  sel_s, exp_sel(1));
            chk("model_chg_sat",  chg_s, exp_chg(1));
        end
    end

    // ---------------- stimulus
    task automatic pulse(input logic [1:0] u, input logic [1:0] d);
        btn_up = u;
        btn_dn = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        btn_up = '0;
        btn_dn = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [1:0] e0;
        bit         ec;
        rst    = 1'b1;
        sw_on  = 1'b1;
        btn_up = 2'b01;
        btn_dn = 2'b00;
        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_sel", sel_w, 4'b0101);
        chk("rst_chg", chg_w, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("held_thru_rst_sel", sel_w, 4'b0101);
            chk("held_thru_rst_chg", chg_w, 2'b00);
        end
        idle(1);

        pulse(2'b01, 2'b00);
        chk("up0_a_w", {chg_w, sel_w}, 6'b01_0110);
        chk("up0_a_s", {chg_s, sel_s}, 6'b01_0110);
        idle(1);
        pulse(2'b01, 2'b00);
        chk("up0_b_w", {chg_w, sel_w}, 6'b01_0100);
        chk("up0_b_s", {chg_s, sel_s}, 6'b00_0110);
        idle(1);
        pulse(2'b01, 2'b00);
        chk("up0_c_w", {chg_w, sel_w}, 6'b01_0101);
        idle(1);

        pulse(2'b00, 2'b10);
        chk("dn1_a_s", {chg_s, sel_s}, 6'b10_0010);
        chk("dn1_a_w", {chg_w, sel_w}, 6'b10_0001);
        idle(1);
        pulse(2'b00, 2'b10);
        chk("dn1_sat_s", {chg_s, sel_s}, 6'b00_0010);
        chk("dn1_wrap_w", {chg_w, sel_w}, 6'b10_1001);
        idle(1);
        pulse(2'b10, 2'b00);
        chk("up1_a_s", {chg_s, sel_s}, 6'b10_0110);
        idle(1);
        pulse(2'b10, 2'b00);
        chk("up1_b_s", {chg_s, sel_s}, 6'b10_1010);
        idle(1);
        pulse(2'b10, 2'b00);
        chk("up1_sat_s", {chg_s, sel_s}, 6'b00_1010);
        idle(1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse(2'b11, 2'b01);
        chk("both0_up1_w", {chg_w, sel_w}, 6'b10_1001);
        chk("both0_up1_s", {chg_s, sel_s}, 6'b10_1001);
        idle(1);

        pulse(2'b01, 2'b00);
        chk("pre_off_w", {chg_w, sel_w}, 6'b01_1010);
        sw_on = 1'b0;
        @(negedge clk);
        chk("off_w", {chg_w, sel_w}, 6'b00_0101);
        chk("off_s", {chg_s, sel_s}, 6'b00_0101);
        sw_on = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("on_held_w", {chg_w, sel_w}, 6'b00_0101);
        end
        idle(1);
        chk("on_release_w", {chg_w, sel_w}, 6'b00_0101);
        pulse(2'b01, 2'b00);
        chk("repress_w", {chg_w, sel_w}, 6'b01_0110);
        idle(1);

        pulse(2'b00, 2'b01);
        idle(1);
        pulse(2'b00, 2'b01);
        chk("ch0_to_zero_w", {chg_w, sel_w}, 6'b01_0100);
        idle(1);

        btn_up = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
`ifdef AUTOREPEAT_EN
            e0 = (i < 8) ? 2'd1 : (i < 12) ? 2'd2 : (i < 16) ? 2'd0 : 2'd1;
            ec = (i == 0) || (i == 8) || (i == 12) || (i == 16);
`else
            e0 = 2'd1;
            ec = (i == 0);
`endif
            chk("hold_sel_w", sel_w, {2'b01, e0});
            chk("hold_chg_w", chg_w, {1'b0, ec});
        end
        btn_dn = 2'b01;
        @(negedge clk);
        chk("opp_press_w", {chg_w, sel_w}, 6'b01_0100);
        repeat (10) begin
            @(negedge clk);
            chk("opp_hold_w", {chg_w, sel_w}, 6'b00_0100);
        end
        idle(2);

        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(149) == 0);
            if (sw_on) begin
                if ($urandom_range(59) == 0) sw_on = 1'b0;
            end else if ($urandom_range(4) == 0) begin
                sw_on = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(11) == 0) btn_up[k] = ~btn_up[k];
                if ($urandom_range(11) == 0) btn_dn[k] = ~btn_dn[k];
            end
            @(negedge clk);
        end
        rst = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
